// File: rtl/wait_mem_pkg.sv
// Shared definitions for the wait-state memory.
//   state_t   : controller state encoding (IDLE, WAIT, DONE)
//   op_t      : latched operation kind (read, write, illegal read+write)
//   WS_MAX    : largest supported WAIT_STATES value
//   CNT_W     : width of the wait-state down-counter
//   ws_clamp  : folds a WAIT_STATES parameter into 0..WS_MAX
package wait_mem_pkg;

    localparam int WS_MAX = 15;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_RD   = 2'd0,
        OP_WR   = 2'd1,
        OP_BOTH = 2'd2
    } op_t;

    // Out-of-range values are clamped rather than rejected so the counter
    // width can never be exceeded.
    function automatic int ws_clamp(input int ws);
        if (ws < 0) begin
            return 0;
        end
        if (ws > WS_MAX) begin
            return WS_MAX;
        end
        return ws;
    endfunction

endpackage

// File: rtl/wait_mem_if.sv
// Request/response bus of the wait-state memory.
//   rd, wr  : read / write request, held by the master until accepted
//   addr    : request address
//   wdata   : write data
//   rdata   : read data, valid with ready and held until the next read
//   ready   : one-cycle completion pulse
//   err     : error flag, valid with ready
//   busy    : high while a request is in flight
// Modports: master drives the request side, slave drives the response side.
interface wait_mem_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 5
);
    logic              rd;
    logic              wr;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
    logic [DWIDTH-1:0] rdata;
    logic              ready;
    logic              err;
    logic              busy;

    modport master (
        output rd, wr, addr, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  rd, wr, addr, wdata,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/wait_mem_array.sv
// Storage array of the wait-state memory.
//   clock : rising-edge clock
//   we    : write enable (single synchronous write port)
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read port)
//   rdata : read data
// Contents are deliberately not reset; the parent selects between preload
// and bus writes before this port.
module wait_mem_array #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 5
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wait_mem.sv
// Wait-state memory: a small RAM behind a request/ready handshake that
// inserts WAIT_STATES extra cycles before each response, with write
// protection of the low address range and a side-band preload port.
//   clock     : rising-edge clock
//   rst_      : synchronous reset, active HIGH despite the name
//   bus       : request/response bus (slave side)
//   load_en   : preload write strobe, honoured only in IDLE, bypasses protection
//   load_addr : preload address
//   load_data : preload data
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no request in flight; preload or accept a new request
//   WAIT    | counting down inserted wait states
//   DONE    | complete the request; ready/err/rdata are registered here and
//           | become visible the cycle after, while the FSM is back in IDLE
module wait_mem
    import wait_mem_pkg::*;
#(
    parameter int DWIDTH      = 8,
    parameter int AWIDTH      = 5,
    parameter int WAIT_STATES = 0,
    parameter int WP_LIMIT    = 0
) (
    input  logic              clock,
    input  logic              rst_,
    wait_mem_if.slave         bus,
    input  logic              load_en,
    input  logic [AWIDTH-1:0] load_addr,
    input  logic [DWIDTH-1:0] load_data
);

    localparam int               WS_EFF = ws_clamp(WAIT_STATES);
    localparam logic [CNT_W-1:0] WS_CNT = CNT_W'(WS_EFF);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    op_t               lat_op;
    logic [AWIDTH-1:0] lat_addr;
    logic [DWIDTH-1:0] lat_wdata;

    logic [DWIDTH-1:0] rdata_q;
    logic              ready_q;
    logic              err_q;
    logic              busy_q;

    logic              wp_hit;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_waddr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    // Signed compare so a WP_LIMIT of 0 simply protects nothing.
    assign wp_hit = ($signed({{(32-AWIDTH){1'b0}}, lat_addr}) < WP_LIMIT);

    // Preload wins only in IDLE; a bus write lands at the DONE edge. Reset
    // blocks both so an aborted write never reaches the array.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = lat_addr;
        mem_wdata = lat_wdata;
        if (!rst_) begin
            if (state == ST_IDLE && load_en) begin
                mem_we    = 1'b1;
                mem_waddr = load_addr;
                mem_wdata = load_data;
            end else if (state == ST_DONE && lat_op == OP_WR && !wp_hit) begin
                mem_we = 1'b1;
            end
        end
    end

    wait_mem_array #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (lat_addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clock) begin
        if (rst_) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A simultaneous preload defers the request by a cycle.
                    if (!load_en && (bus.rd || bus.wr)) begin
                        lat_addr  <= bus.addr;
                        lat_wdata <= bus.wdata;
                        if (bus.rd && bus.wr) begin
                            lat_op <= OP_BOTH;
                        end else if (bus.wr) begin
                            lat_op <= OP_WR;
                        end else begin
                            lat_op <= OP_RD;
                        end
                        cnt    <= WS_CNT;
                        busy_q <= 1'b1;
                        state  <= (WS_EFF > 0) ? ST_WAIT : ST_DONE;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                    case (lat_op)
                        OP_RD:   rdata_q <= mem_rdata;
                        OP_WR:   err_q   <= wp_hit;
                        default: err_q   <= 1'b1;
                    endcase
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_wait_mem.sv
`timescale 1ns/1ps
module tb_wait_mem;

    // Instance 0: WAIT_STATES=0, WP_LIMIT=8
    // Instance 1: WAIT_STATES=3, WP_LIMIT=0
    // Instance 2: WAIT_STATES=5, WP_LIMIT=0
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rst_v;
    logic [2:0]      rd_v, wr_v, load_en_v;
    logic [2:0][4:0] addr_v, load_addr_v;
    logic [2:0][7:0] wdata_v, load_data_v;
    logic [2:0][7:0] rdata_v;
    logic [2:0]      ready_v, err_v, busy_v;

    int n_chk  = 0;
    int n_fail = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        wait_mem_if #(.DWIDTH(8), .AWIDTH(5)) bus ();

        assign bus.rd    = rd_v[gi];
        assign bus.wr    = wr_v[gi];
        assign bus.addr  = addr_v[gi];
        assign bus.wdata = wdata_v[gi];
        assign rdata_v[gi] = bus.rdata;
        assign ready_v[gi] = bus.ready;
        assign err_v[gi]   = bus.err;
        assign busy_v[gi]  = bus.busy;

        wait_mem #(
            .DWIDTH      (8),
            .AWIDTH      (5),
            .WAIT_STATES ((gi == 0) ? 0 : ((gi == 1) ? 3 : 5)),
            .WP_LIMIT    ((gi == 0) ? 8 : 0)
        ) u_dut (
            .clock     (clk),
            .rst_      (rst_v[gi]),
            .bus       (bus),
            .load_en   (load_en_v[gi]),
            .load_addr (load_addr_v[gi]),
            .load_data (load_data_v[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [4:0] a, input logic [7:0] d);
        load_en_v[k]   = 1'b1;
        load_addr_v[k] = a;
        load_data_v[k] = d;
        tick();
        load_en_v[k] = 1'b0;
    endtask

    // Presents a request, counts edges until accepted (busy seen), drops the
    // request, then counts cycles from acceptance to ready and busy cycles.
    task automatic issue(input int k, input logic r, input logic w,
                         input logic [4:0] a, input logic [7:0] d,
                         output int acc, output int lat, output int bc);
        rd_v[k]    = r;
        wr_v[k]    = w;
        addr_v[k]  = a;
        wdata_v[k] = d;
        acc = 0;
        do begin
            tick();
            acc++;
        end while (!busy_v[k] && acc < 10);
        rd_v[k]    = 1'b0;
        wr_v[k]    = 1'b0;
        addr_v[k]  = ~a;
        wdata_v[k] = ~d;
        lat = 0;
        bc  = busy_v[k] ? 1 : 0;
        if (!busy_v[k]) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            while (!ready_v[k] && lat < 40) begin
                tick();
                lat++;
                if (busy_v[k]) bc++;
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int acc, lat, bc;
        rst_v = 3'b111;
        rd_v = '0; wr_v = '0; load_en_v = '0;
        addr_v = '0; wdata_v = '0; load_addr_v = '0; load_data_v = '0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            check("rst_ready", 32'(ready_v[k]), 32'd0);
            check("rst_busy",  32'(busy_v[k]),  32'd0);
            check("rst_err",   32'(err_v[k]),   32'd0);
            check("rst_rdata", 32'(rdata_v[k]), 32'h00);
        end
        rst_v = 3'b000;
        tick();

        // WS=0: preload then read, one-cycle latency, ready is a single pulse
        load(0, 5'd3, 8'hA5);
        issue(0, 1'b1, 1'b0, 5'd3, 8'h00, acc, lat, bc);
        check("s1_lat",   32'(lat), 32'd1);
        check("s1_busy",  32'(bc), 32'd1);
        check("s1_rdata", 32'(rdata_v[0]), 32'hA5);
        check("s1_err",   32'(err_v[0]), 32'd0);
        tick();
        check("s1_ready_pulse", 32'(ready_v[0]), 32'd0);
        check("s1_rdata_hold",  32'(rdata_v[0]), 32'hA5);

        // WP_LIMIT=8: protected write to 2 rejected, preload survives
        load(0, 5'd2, 8'h5A);
        issue(0, 1'b0, 1'b1, 5'd2, 8'hFF, acc, lat, bc);
        check("wp_lat", 32'(lat), 32'd1);
        check("wp_err", 32'(err_v[0]), 32'd1);
        issue(0, 1'b1, 1'b0, 5'd2, 8'h00, acc, lat, bc);
        check("wp_rdata", 32'(rdata_v[0]), 32'h5A);
        check("wp_rd_err", 32'(err_v[0]), 32'd0);

        // Boundary: 7 is protected, 8 is not
        load(0, 5'd7, 8'h07);
        issue(0, 1'b0, 1'b1, 5'd7, 8'hE7, acc, lat, bc);
        check("wp7_err", 32'(err_v[0]), 32'd1);
        issue(0, 1'b0, 1'b1, 5'd8, 8'hE8, acc, lat, bc);
        check("wp8_err", 32'(err_v[0]), 32'd0);
        issue(0, 1'b1, 1'b0, 5'd8, 8'h00, acc, lat, bc);
        check("wp8_rdata", 32'(rdata_v[0]), 32'hE8);
        issue(0, 1'b1, 1'b0, 5'd7, 8'h00, acc, lat, bc);
        check("wp7_rdata", 32'(rdata_v[0]), 32'h07);

        // rd and wr together: err, memory and rdata untouched
        load(0, 5'd10, 8'h77);
        issue(0, 1'b1, 1'b1, 5'd10, 8'h99, acc, lat, bc);
        check("both_lat",   32'(lat), 32'd1);
        check("both_err",   32'(err_v[0]), 32'd1);
        check("both_rdata", 32'(rdata_v[0]), 32'h07);
        issue(0, 1'b1, 1'b0, 5'd10, 8'h00, acc, lat, bc);
        check("both_mem", 32'(rdata_v[0]), 32'h77);

        // Preload and read in the same IDLE cycle: read deferred one cycle
        load_en_v[0]   = 1'b1;
        load_addr_v[0] = 5'd20;
        load_data_v[0] = 8'hC3;
        rd_v[0]        = 1'b1;
        addr_v[0]      = 5'd20;
        tick();
        check("ld_defer_busy", 32'(busy_v[0]), 32'd0);
        load_en_v[0] = 1'b0;
        issue(0, 1'b1, 1'b0, 5'd20, 8'h00, acc, lat, bc);
        check("ld_acc",   32'(acc), 32'd1);
        check("ld_rdata", 32'(rdata_v[0]), 32'hC3);

        // WS=3: four-cycle latency and busy for write and read of 0x1F
        issue(1, 1'b0, 1'b1, 5'h1F, 8'h3C, acc, lat, bc);
        check("ws3_wr_lat",  32'(lat), 32'd4);
        check("ws3_wr_busy", 32'(bc), 32'd4);
        check("ws3_wr_err",  32'(err_v[1]), 32'd0);
        issue(1, 1'b1, 1'b0, 5'h1F, 8'h00, acc, lat, bc);
        check("ws3_rd_lat",   32'(lat), 32'd4);
        check("ws3_rd_busy",  32'(bc), 32'd4);
        check("ws3_rd_rdata", 32'(rdata_v[1]), 32'h3C);

        // WS=5: reset during WAIT of a write aborts it
        load(2, 5'd4, 8'h22);
        wr_v[2] = 1'b1; addr_v[2] = 5'd4; wdata_v[2] = 8'h11;
        tick();
        check("abort_accept", 32'(busy_v[2]), 32'd1);
        wr_v[2] = 1'b0;
        tick();
        rst_v[2] = 1'b1;
        tick();
        check("abort_busy",  32'(busy_v[2]), 32'd0);
        check("abort_ready", 32'(ready_v[2]), 32'd0);
        rst_v[2] = 1'b0;
        repeat (8) tick();
        check("abort_no_ready", 32'(ready_v[2]), 32'd0);
        issue(2, 1'b1, 1'b0, 5'd4, 8'h00, acc, lat, bc);
        check("abort_rd_lat", 32'(lat), 32'd6);
        check("abort_mem",    32'(rdata_v[2]), 32'h22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
